// File: rtl/ysyx_25030085_isram.sv
// Word-addressed SRAM responder with valid/ready request and response channels,
// a fixed access latency, byte-masked writes and range/alignment error reporting.
module ysyx_25030085_isram #(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    logic [31:0] cap_addr;
    logic        cap_wen;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wmask;

    logic [31:0] mem [DEPTH];

    logic [31:0]      offset;
    logic [31:0]      idx_full;
    logic [IDX_W-1:0] idx;
    logic             acc_err;
    logic             access_now;
    logic             do_write;

    // The range test uses the untruncated word index so that high addresses never alias.
    assign offset     = cap_addr - BASE_ADDR;
    assign idx_full   = offset >> 2;
    assign idx        = idx_full[IDX_W-1:0];
    assign acc_err    = (cap_addr[1:0] != 2'b00) || (cap_addr < BASE_ADDR) ||
                        (idx_full >= 32'(DEPTH));
    assign access_now = (state == WAIT) && (cnt == 4'd0);
    assign do_write   = access_now && cap_wen && !acc_err;

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            cap_addr  <= req_addr;
            cap_wen   <= req_wen;
            cap_wdata <= req_wdata;
            cap_wmask <= req_wmask;
        end
    end

    // Storage is deliberately left out of reset; a reset only suppresses the pending commit.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_wmask[i]) begin
                    mem[idx][8*i +: 8] <= cap_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cnt   <= 4'(LATENCY - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || cap_wen) ? 32'd0 : mem[idx];
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25030085_isram.sv
// Bench for ysyx_25030085_isram: one instance at LATENCY=1 and one at LATENCY=3,
// driven from a vector table, hand-written corner sequences and a random phase.
module tb_ysyx_25030085_isram;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] WIN   = 32'h8000_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_addr [2];
    logic [1:0]  req_wen;
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wmask [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_rdata [2];
    logic [1:0]  rsp_err;

    ysyx_25030085_isram #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .req_wen(req_wen[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    ysyx_25030085_isram #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(3)) dut_l3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .req_wen(req_wen[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    // Reference memory, keyed by instance and word index; only written words are ever read.
    logic [31:0] model_mem [longint];

    function automatic int dut_latency(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic model_err(input logic [31:0] addr);
        longint off;
        off = longint'(addr) - longint'(BASE);
        return (addr % 4 != 0) || (off < 0) || (off / 4 >= DEPTH);
    endfunction

    function automatic longint model_key(input int d, input logic [31:0] addr);
        return longint'(d) * 64'd1_000_000 + (longint'(addr) - longint'(BASE)) / 4;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] mask);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    function automatic void model_write(input int d, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] mask);
        longint k;
        logic [31:0] old_w;
        k = model_key(d, addr);
        old_w = model_mem.exists(k) ? model_mem[k] : 32'd0;
        model_mem[k] = merge_bytes(old_w, wdata, mask);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Entered and left at a negedge; runs one full handshaked transaction.
    task automatic applyStimulus(input int d, input logic wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wmask, input int gap,
                                 output logic [31:0] rdata, output logic err, output int lat);
        repeat (gap) @(negedge clk);
        req_valid[d] = 1'b1;
        req_wen[d]   = wen;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_wmask[d] = wmask;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_wen[d]   = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_wmask[d] = 4'($urandom);
        lat = 0;
        while (!rsp_valid[d] && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
    endtask

    task automatic runVec(input int d, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask, input int gap,
                          input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        logic [31:0] rdata;
        logic        err;
        int          lat;
        applyStimulus(d, wen, addr, wdata, wmask, gap, rdata, err, lat);
        checkOutput({tag, " rdata"}, rdata, exp_rdata);
        checkOutput({tag, " err"}, 32'(err), 32'(exp_err));
        checkOutput({tag, " latency"}, 32'(lat), 32'(dut_latency(d)));
        checkOutput({tag, " idle"}, {30'd0, rsp_valid[d], req_ready[d]}, 32'd1);
    endtask

    // Random traffic checked against the reference model; the window is pre-filled first.
    task automatic randomPhase(input int d, input int n);
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          r;
        for (int i = 0; i < 16; i++) begin
            wdata = $urandom;
            runVec(d, 1'b1, WIN + 32'(4 * i), wdata, 4'hF, 0, 32'd0, 1'b0, "fill");
            model_write(d, WIN + 32'(4 * i), wdata, 4'hF);
        end
        for (int i = 0; i < n; i++) begin
            r     = int'($urandom_range(0, 99));
            wen   = 1'($urandom);
            wdata = $urandom;
            mask  = 4'($urandom);
            if (r < 80)      addr = WIN + 32'(4 * $urandom_range(0, 15));
            else if (r < 87) addr = WIN + 32'($urandom_range(1, 3)) + 32'(4 * $urandom_range(0, 15));
            else if (r < 93) addr = BASE - 32'(4 * $urandom_range(1, 1000));
            else             addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
            exp_err   = model_err(addr);
            exp_rdata = (exp_err || wen) ? 32'd0 : model_mem[model_key(d, addr)];
            runVec(d, wen, addr, wdata, mask, int'($urandom_range(0, 3)), exp_rdata, exp_err, "random");
            if (!exp_err && wen) model_write(d, addr, wdata, mask);
        end
    endtask

    initial begin
        logic [31:0] rdata;
        logic [31:0] held;
        logic        err;
        int          lat;
        int          stray;

        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_wen   = 2'b00;
        for (int d = 0; d < 2; d++) begin
            req_addr[d]  = BASE;
            req_wdata[d] = 32'd0;
            req_wmask[d] = 4'hF;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("reset req_ready", 32'(req_ready[d]), 32'd1);
            checkOutput("reset rsp_valid", 32'(rsp_valid[d]), 32'd0);
            checkOutput("reset rsp_rdata", rsp_rdata[d], 32'd0);
            checkOutput("reset rsp_err", 32'(rsp_err[d]), 32'd0);
        end
        rst       = 1'b0;
        req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("post-reset nothing accepted", {30'd0, rsp_valid[d], req_ready[d]}, 32'd1);
        end

        vecs.push_back('{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF,    32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0,    32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0,    32'hDE22_BE44, 1'b0});
        vecs.push_back('{1'b0, 32'h8000_0002, 32'h0,         4'h0,    32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF,    32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 32'h7FFF_FFFC, 32'h5555_5555, 4'hF,    32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 32'h8000_4000, 32'h6666_6666, 4'hF,    32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'h0,         4'h0,    32'hCAFE_F00D, 1'b0});
        vecs.push_back('{1'b1, 32'h8000_0010, 32'h9999_9999, 4'h0,    32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0,    32'hDE22_BE44, 1'b0});
        vecs.push_back('{1'b1, 32'h8000_3FFC, 32'h1234_5678, 4'hF,    32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 32'h8000_3FFC, 32'h0,         4'h0,    32'h1234_5678, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0,    32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 32'h8000_0011, 32'h7777_7777, 4'hF,    32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0,    32'hDE22_BE44, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            runVec(0, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, i % 2,
                   vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
            if (!vecs[i].exp_err && vecs[i].wen) model_write(0, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
        end

        // LATENCY=3 backpressure: response must hold while rsp_ready stays low.
        runVec(1, 1'b1, 32'h8000_0200, 32'hA5A5_5A5A, 4'hF, 0, 32'd0, 1'b0, "bp setup");
        req_valid[1] = 1'b1;
        req_wen[1]   = 1'b0;
        req_addr[1]  = 32'h8000_0200;
        @(posedge clk);
        @(negedge clk);
        req_wen[1]   = 1'b1;
        req_wdata[1] = 32'h0;
        req_wmask[1] = 4'hF;
        lat = 0;
        while (!rsp_valid[1] && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput("bp latency", 32'(lat), 32'd3);
        held = rsp_rdata[1];
        checkOutput("bp rdata", held, 32'hA5A5_5A5A);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp hold valid", 32'(rsp_valid[1]), 32'd1);
            checkOutput("bp hold rdata", rsp_rdata[1], 32'hA5A5_5A5A);
            checkOutput("bp hold err", 32'(rsp_err[1]), 32'd0);
            checkOutput("bp hold req_ready", 32'(req_ready[1]), 32'd0);
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[1] = 1'b0;
        checkOutput("bp release idle", {30'd0, rsp_valid[1], req_ready[1]}, 32'd1);
        checkOutput("bp release rdata", rsp_rdata[1], 32'd0);
        runVec(1, 1'b0, 32'h8000_0200, 32'd0, 4'h0, 0, 32'hA5A5_5A5A, 1'b0, "bp ignored write");

        // Reset during WAIT must drop the pending write and never respond.
        runVec(1, 1'b1, 32'h8000_0204, 32'h1357_9BDF, 4'hF, 0, 32'd0, 1'b0, "rst setup");
        req_valid[1] = 1'b1;
        req_wen[1]   = 1'b1;
        req_addr[1]  = 32'h8000_0204;
        req_wdata[1] = 32'hFFFF_FFFF;
        req_wmask[1] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid[1] || !req_ready[1]) stray++;
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("rst abort no response", 32'(stray), 32'd0);
        runVec(1, 1'b0, 32'h8000_0204, 32'd0, 4'h0, 0, 32'h1357_9BDF, 1'b0, "rst old value");
        model_write(1, 32'h8000_0204, 32'h1357_9BDF, 4'hF);

        randomPhase(0, 60);
        randomPhase(1, 30);

        applyStimulus(0, 1'b0, 32'h8000_3FFC, 32'd0, 4'h0, 0, rdata, err, lat);
        checkOutput("final top word", rdata, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
